// File: rtl/mux_rr_arbiter_pkg.sv
// Shared types, source indices and the round-robin pick function for the arbiter.
package mux_arb_pkg;

    typedef enum logic [0:0] {
        IDLE,
        GRANT
    } state_e;

    localparam logic [1:0] SRC_A = 2'd0;
    localparam logic [1:0] SRC_B = 2'd1;
    localparam logic [1:0] SRC_C = 2'd2;
    localparam logic [1:0] SRC_D = 2'd3;

    // Returns {found, index} of the first set request searching ptr, ptr+1, ... mod 4.
    function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        // Walk from farthest to nearest so the nearest set bit is written last.
        for (int i = 3; i >= 0; i--) begin
            idx = ptr + 2'(i);
            if (req[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// Request/data/grant bundle between the four producers and the arbiter.
interface mux_rr_arbiter_if #(
    parameter int unsigned DW = 1
);
    logic [3:0]    req;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] c;
    logic [DW-1:0] d;
    logic [3:0]    gnt;
    logic          gnt_valid;
    logic [1:0]    sel;
    logic [DW-1:0] y;

    // Producer side: drives requests and data, observes grants.
    modport master (
        output req, a, b, c, d,
        input  gnt, gnt_valid, sel, y
    );

    // Arbiter side.
    modport slave (
        input  req, a, b, c, d,
        output gnt, gnt_valid, sel, y
    );
endinterface

// File: rtl/mux_rr_arbiter_rr_pick4.sv
// Combinational rotate-and-find over four request bits.
module rr_pick4
    import mux_arb_pkg::*;
(
    input  logic [3:0] req_i,
    input  logic [1:0] ptr_i,
    output logic [1:0] idx_o,
    output logic       found_o
);

    assign {found_o, idx_o} = rr_pick(req_i, ptr_i);

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 mux; each grant is held for at most HOLD cycles.
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int unsigned DW   = 1,
    parameter int unsigned HOLD = 4
) (
    input  logic                clk,
    input  logic                rst,
    mux_rr_arbiter_if.slave     bus
);

    localparam logic [3:0] HoldM1 = 4'(HOLD - 1);

    state_e        state_q, state_d;
    logic [3:0]    gnt_q, gnt_d;
    logic          gnt_valid_q, gnt_valid_d;
    logic [1:0]    sel_q, sel_d;
    logic [1:0]    ptr_q, ptr_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [DW-1:0] y_c;

    logic          release_c;
    logic [1:0]    pick_ptr;
    logic [1:0]    win;
    logic          found;
    logic          grant_new;

    // A grant ends when its owner drops the request or its hold budget is spent.
    assign release_c = (state_q == GRANT) && (!bus.req[sel_q] || (cnt_q == 4'd0));
    // Re-arbitration on a release edge already uses the rotated pointer.
    assign pick_ptr  = release_c ? sel_q + 2'd1 : ptr_q;

    rr_pick4 u_pick (
        .req_i   (bus.req),
        .ptr_i   (pick_ptr),
        .idx_o   (win),
        .found_o (found)
    );

    // State register: FSM state, pointer, hold counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            gnt_q       <= 4'b0000;
            gnt_valid_q <= 1'b0;
            sel_q       <= 2'b00;
            ptr_q       <= 2'b00;
            cnt_q       <= 4'd0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_valid_q <= gnt_valid_d;
            sel_q       <= sel_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
        end
    end

    // Next-state: decide grant/hold/release and update pointer and counter.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        grant_new = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d   = GRANT;
                    grant_new = 1'b1;
                    cnt_d     = HoldM1;
                end
            end
            GRANT: begin
                if (release_c) begin
                    ptr_d = pick_ptr;
                    if (found) begin
                        grant_new = 1'b1;
                        cnt_d     = HoldM1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: next grant/select registers and the gated data mux.
    always_comb begin
        gnt_d       = gnt_q;
        sel_d       = sel_q;
        gnt_valid_d = gnt_valid_q;
        if (grant_new) begin
            gnt_d       = 4'b0001 << win;
            sel_d       = win;
            gnt_valid_d = 1'b1;
        end else if (state_d == IDLE) begin
            // sel keeps its last value while idle
            gnt_d       = 4'b0000;
            gnt_valid_d = 1'b0;
        end

        y_c = '0;
        if (gnt_valid_q) begin
            case (sel_q)
                SRC_A:   y_c = bus.a;
                SRC_B:   y_c = bus.b;
                SRC_C:   y_c = bus.c;
                SRC_D:   y_c = bus.d;
                default: y_c = '0;
            endcase
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_valid = gnt_valid_q;
    assign bus.sel       = sel_q;
    assign bus.y         = y_c;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter with HOLD=4, DW=1.
module tb_mux_rr_arbiter;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    mux_rr_arbiter_if #(.DW(1)) bus ();

    mux_rr_arbiter #(
        .DW   (1),
        .HOLD (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; return at the falling edge for sampling and driving.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Check grant, select, valid and mux output; data pattern is a=0 b=1 c=0 d=1.
    task automatic expect_state(input string tag, input logic [3:0] g, input logic [1:0] s,
                                input logic v);
        logic [1:0] ss;
        ss = s;
        check_eq({tag, ".gnt"}, 32'(bus.gnt), 32'(g));
        check_eq({tag, ".sel"}, 32'(bus.sel), 32'(s));
        check_eq({tag, ".valid"}, 32'(bus.gnt_valid), 32'(v));
        check_eq({tag, ".y"}, 32'(bus.y), v ? 32'(ss[0]) : 32'd0);
    endtask

    initial begin
        logic [1:0] src;
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        bus.req = 4'hF;
        bus.a   = 1'b0;
        bus.b   = 1'b1;
        bus.c   = 1'b0;
        bus.d   = 1'b1;

        // Reset held two edges with all requesting.
        tick();
        tick();
        expect_state("reset", 4'b0000, 2'b00, 1'b0);
        rst = 1'b0;

        // Full contention: each source 4 cycles, order 0,1,2,3,0; y follows data.
        for (int g = 0; g < 5; g++) begin
            for (int k = 0; k < 4; k++) begin
                tick();
                src = 2'(g);
                expect_state($sformatf("rot%0d_%0d", g, k), 4'b0001 << src, src, 1'b1);
            end
        end
        bus.req = 4'b0000;
        tick();
        expect_state("rot_idle", 4'b0000, 2'b00, 1'b0);

        // Sole requester: continuous re-grant with no gap.
        bus.req = 4'b0100;
        for (int k = 0; k < 12; k++) begin
            tick();
            expect_state($sformatf("sole%0d", k), 4'b0100, 2'd2, 1'b1);
        end
        bus.req = 4'b0000;
        tick();
        expect_state("sole_idle", 4'b0000, 2'd2, 1'b0);

        // Early release: ptr=3 so source 0 wins; drop req[0] after 2 grant cycles.
        bus.req = 4'b0011;
        tick();
        expect_state("early0", 4'b0001, 2'd0, 1'b1);
        tick();
        expect_state("early1", 4'b0001, 2'd0, 1'b1);
        bus.req = 4'b0010;
        tick();
        expect_state("early_sw", 4'b0010, 2'd1, 1'b1);
        bus.req = 4'b0000;
        tick();
        expect_state("early_idle", 4'b0000, 2'd1, 1'b0);

        // Mid-grant reset during 2nd cycle of a source-2 grant.
        bus.req = 4'b0100;
        tick();
        expect_state("mid0", 4'b0100, 2'd2, 1'b1);
        tick();
        expect_state("mid1", 4'b0100, 2'd2, 1'b1);
        rst = 1'b1;
        tick();
        expect_state("mid_rst", 4'b0000, 2'd0, 1'b0);
        rst = 1'b0;
        tick();
        expect_state("regrant0", 4'b0100, 2'd2, 1'b1);
        // Competitor waits; source 2 must keep a full 4-cycle hold.
        bus.req = 4'b0101;
        for (int k = 1; k < 4; k++) begin
            tick();
            expect_state($sformatf("regrant%0d", k), 4'b0100, 2'd2, 1'b1);
        end
        tick();
        expect_state("regrant_next", 4'b0001, 2'd0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
